// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
//
// Purpose:
//   Register-access front end for an SPI slave byte engine. The first byte of
//   a frame is a command {rd_nwr, addr[6:0]}. On a write, the following bytes
//   go to consecutive registers. On a read, the following byte slots return
//   consecutive registers. The address increments modulo 128.
//   While the command byte shifts, the master receives the STATUS byte.
//
// Optional feature (macro SPI_REG_CTRL_WPROT_EN):
//   Adds an internal write-protect lock bit at address 7'h7F.
//   - Writing 8'h5A to 7'h7F clears the lock. Writing any other value sets it.
//   - While the lock is set, reg_we is suppressed.
//   - reg_we is never asserted for 7'h7F.
//   - A read of 7'h7F returns {7'b0, lock} and does not assert reg_re.
//   Without the macro, 7'h7F is an ordinary external register.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   spi_start  in   one-cycle pulse when the master selects (starts a frame)
//   spi_done   in   one-cycle pulse when a byte has been shifted
//   spi_select in   synchronized chip-select level, active high
//   spi_dout   in   [7:0] byte received from the master (valid with spi_done)
//   spi_din    out  [7:0] next byte to send to the master
//   reg_addr   out  [6:0] register address
//   reg_wdata  out  [7:0] register write data
//   reg_we     out  one-cycle write strobe
//   reg_re     out  one-cycle read strobe; reg_rdata is valid one cycle later
//   reg_rdata  in   [7:0] register read data
//   frame_err  out  one-cycle pulse when a frame aborts inside its command byte
//
// Timing notes:
//   A read strobe is issued in the cycle after spi_done. spi_din is loaded two
//   clock edges after the edge that sampled spi_done.
//   A write strobe is issued in the cycle after spi_done, and reg_addr advances
//   on the following edge. Consecutive spi_done pulses are assumed to be at
//   least two cycles apart, which a byte engine always satisfies.
// ---------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter logic [7:0] STATUS = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_start,
    input  logic       spi_done,
    input  logic       spi_select,
    input  logic [7:0] spi_dout,
    output logic [7:0] spi_din,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RD   = 2'd3;

    logic [1:0] r_state;
    logic [7:0] r_spi_din;
    logic [6:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_reg_we;
    logic       r_reg_re;
    logic       r_frame_err;
    logic       r_rd_s1;     // read issued on the previous edge
    logic       r_rd_s2;     // read data is available for loading on this edge
    logic       r_wr_inc;    // a write strobe is out; advance the address next

    logic       w_done_cmd;
    logic       w_done_rd;
    logic       w_done_wr;
    logic       w_rd_issue;
    logic       w_abort;
    logic       w_we_allow;
    logic       w_rd_lock_addr;
    logic [7:0] w_rd_data;

    // spi_start takes priority over a coincident spi_done. spi_done is
    // ignored in IDLE because no state term matches.
    assign w_done_cmd = spi_done && !spi_start && (r_state == ST_CMD);
    assign w_done_rd  = spi_done && !spi_start && (r_state == ST_RD);
    assign w_done_wr  = spi_done && !spi_start && (r_state == ST_WR);
    assign w_rd_issue = (w_done_cmd && spi_dout[7]) || w_done_rd;
    assign w_abort    = !spi_start && !spi_select && (r_state != ST_IDLE);

`ifdef SPI_REG_CTRL_WPROT_EN
    localparam logic [6:0] LOCK_ADDR  = 7'h7F;
    localparam logic [7:0] UNLOCK_KEY = 8'h5A;

    logic       r_lock;
    logic       r_rd_lk_s1;
    logic       r_rd_lk_s2;
    logic [6:0] w_rd_addr;

    // Address that the read being issued on this edge will target.
    assign w_rd_addr      = w_done_cmd ? spi_dout[6:0] : (r_reg_addr + 7'd1);
    assign w_rd_lock_addr = w_rd_issue && (w_rd_addr == LOCK_ADDR);
    assign w_we_allow     = (r_reg_addr != LOCK_ADDR) && !r_lock;
    assign w_rd_data      = r_rd_lk_s2 ? {7'b0000000, r_lock} : reg_rdata;

    // Lock bit and the internal-read pipeline that tracks reads of the lock.
    // The lock survives spi_start; only reset or a write to LOCK_ADDR changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock     <= 1'b1;
            r_rd_lk_s1 <= 1'b0;
            r_rd_lk_s2 <= 1'b0;
        end else begin
            if (spi_start) begin
                r_rd_lk_s1 <= 1'b0;
                r_rd_lk_s2 <= 1'b0;
            end else begin
                r_rd_lk_s1 <= w_rd_lock_addr;
                r_rd_lk_s2 <= r_rd_lk_s1;
            end
            if (w_done_wr && (r_reg_addr == LOCK_ADDR)) begin
                r_lock <= (spi_dout != UNLOCK_KEY);
            end else begin
                r_lock <= r_lock;
            end
        end
    end
`else
    assign w_rd_lock_addr = 1'b0;
    assign w_we_allow     = 1'b1;
    assign w_rd_data      = reg_rdata;
`endif

    // Frame FSM, address counter, strobe generation and the spi_din byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_spi_din   <= 8'h00;
            r_reg_addr  <= 7'h00;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_s1     <= 1'b0;
            r_rd_s2     <= 1'b0;
            r_wr_inc    <= 1'b0;
        end else begin
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_frame_err <= 1'b0;
            if (spi_start) begin
                // A new frame discards any in-flight work from the old one.
                r_state   <= ST_CMD;
                r_spi_din <= STATUS;
                r_rd_s1   <= 1'b0;
                r_rd_s2   <= 1'b0;
                r_wr_inc  <= 1'b0;
            end else begin
                r_rd_s1  <= w_rd_issue;
                r_rd_s2  <= r_rd_s1;
                r_wr_inc <= w_done_wr;
                r_reg_re <= w_rd_issue && !w_rd_lock_addr;

                if (r_rd_s2) begin
                    r_spi_din <= w_rd_data;
                end else if (w_done_cmd && !spi_dout[7]) begin
                    r_spi_din <= 8'h00;
                end else begin
                    r_spi_din <= r_spi_din;
                end

                // Reads pre-increment, so the strobe carries the new address.
                // Writes post-increment, after the strobe has gone out.
                if (w_done_cmd) begin
                    r_reg_addr <= spi_dout[6:0];
                end else if (w_done_rd || r_wr_inc) begin
                    r_reg_addr <= r_reg_addr + 7'd1;
                end else begin
                    r_reg_addr <= r_reg_addr;
                end

                if (w_done_wr) begin
                    r_reg_wdata <= spi_dout;
                    r_reg_we    <= w_we_allow;
                end else begin
                    r_reg_wdata <= r_reg_wdata;
                end

                // Deselect always wins the next state. Strobes from a
                // coincident byte still go out once.
                if (w_abort) begin
                    r_state     <= ST_IDLE;
                    r_frame_err <= (r_state == ST_CMD) && !spi_done;
                end else if (w_done_cmd) begin
                    r_state <= spi_dout[7] ? ST_RD : ST_WR;
                end else begin
                    r_state <= r_state;
                end
            end
        end
    end

    assign spi_din   = r_spi_din;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign reg_re    = r_reg_re;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_ctrl
//
// Purpose:
//   Self-checking bench for spi_reg_ctrl. A register-file environment answers
//   the strobes and logs them. A plain array reference model predicts the
//   register contents from the frames sent, and that prediction is compared
//   with the strobe log and with spi_din.
//
// Build:
//   Define SPI_REG_CTRL_WPROT_EN for both the DUT and the bench to exercise
//   the lock feature.
// ---------------------------------------------------------------------------
module tb_spi_reg_ctrl;

    logic       clk;
    logic       rst;
    logic       spi_start;
    logic       spi_done;
    logic       spi_select;
    logic [7:0] spi_dout;
    logic [7:0] spi_din;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem     [128];
    logic [7:0] ref_mem [128];
    logic [6:0] we_addr_q [$];
    logic [7:0] we_data_q [$];
    logic [6:0] re_addr_q [$];
    int         both_cnt = 0;
    int         ferr_cnt = 0;
    logic       bd_en;
    logic [6:0] bd_addr;
    logic [7:0] bd_data;

    spi_reg_ctrl #(.STATUS(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_start  (spi_start),
        .spi_done   (spi_done),
        .spi_select (spi_select),
        .spi_dout   (spi_dout),
        .spi_din    (spi_din),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file with one-cycle read latency, plus a strobe and event log.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else if (bd_en) begin
            mem[bd_addr] <= bd_data;
        end
        if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) begin
            reg_rdata <= mem[reg_addr];
            re_addr_q.push_back(reg_addr);
        end
        if (reg_we && reg_re) both_cnt <= both_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        spi_select = 1'b1;
        spi_start  = 1'b1;
        tick();
        spi_start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(2, 4)) tick();
        spi_dout = b;
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        spi_dout = 8'($urandom);
    endtask

    task automatic end_frame();
        repeat (2) tick();
        spi_select = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            spi_start  = 1'($urandom_range(0, 1));
            spi_done   = 1'($urandom_range(0, 1));
            spi_select = 1'($urandom_range(0, 1));
            spi_dout   = 8'($urandom);
            tick();
            checks++;
            if ({spi_din, reg_addr, reg_wdata, reg_we, reg_re, frame_err} !== 26'd0) begin
                errors++;
                $display("FAIL reset_state: din=%h addr=%h wdata=%h we=%b re=%b ferr=%b required all zero",
                         spi_din, reg_addr, reg_wdata, reg_we, reg_re, frame_err);
            end
        end
        spi_start  = 1'b0;
        spi_done   = 1'b0;
        spi_select = 1'b0;
        rst        = 1'b0;
        repeat (2) tick();
    endtask

`ifdef SPI_REG_CTRL_WPROT_EN
    task automatic test_wprot();
        int wb;
        int rb;
        wb = we_addr_q.size();
        start_frame();
        send_byte(8'h02);
        send_byte(8'h10);
        end_frame();
        checks++;
        if (we_addr_q.size() != wb) begin
            errors++;
            $display("FAIL wprot_locked: writes=%0d required 0", we_addr_q.size() - wb);
        end
        start_frame();
        send_byte(8'h7F);
        send_byte(8'h5A);
        end_frame();
        checks++;
        if (we_addr_q.size() != wb) begin
            errors++;
            $display("FAIL wprot_lock_addr: writes=%0d required 0", we_addr_q.size() - wb);
        end
        start_frame();
        send_byte(8'h02);
        send_byte(8'h10);
        end_frame();
        ref_mem[2] = 8'h10;
        checks++;
        if (we_addr_q.size() != wb + 1) begin
            errors++;
            $display("FAIL wprot_unlocked: writes=%0d required 1", we_addr_q.size() - wb);
        end else if (we_addr_q[wb] !== 7'h02 || we_data_q[wb] !== 8'h10) begin
            errors++;
            $display("FAIL wprot_unlocked: addr=%h data=%h required 02/10", we_addr_q[wb], we_data_q[wb]);
        end
        rb = re_addr_q.size();
        start_frame();
        send_byte(8'hFF);
        tick();
        tick();
        checks++;
        if (spi_din !== 8'h00) begin
            errors++;
            $display("FAIL wprot_read_lock: spi_din=%h required 00", spi_din);
        end
        end_frame();
        checks++;
        if (re_addr_q.size() != rb) begin
            errors++;
            $display("FAIL wprot_read_strobe: reads=%0d required 0", re_addr_q.size() - rb);
        end
    endtask
`endif

    task automatic test_write_basic();
        int wb;
        logic [6:0] ea [2];
        logic [7:0] ed [2];
        ea[0] = 7'h05; ea[1] = 7'h06;
        ed[0] = 8'h11; ed[1] = 8'h22;
        wb = we_addr_q.size();
        start_frame();
        checks++;
        if (spi_din !== 8'hA5) begin
            errors++;
            $display("FAIL wr_status: spi_din=%h required a5", spi_din);
        end
        send_byte(8'h05);
        checks++;
        if (spi_din !== 8'h00) begin
            errors++;
            $display("FAIL wr_din_zero: spi_din=%h required 00", spi_din);
        end
        send_byte(8'h11);
        send_byte(8'h22);
        end_frame();
        ref_mem[5] = 8'h11;
        ref_mem[6] = 8'h22;
        checks++;
        if (we_addr_q.size() != wb + 2) begin
            errors++;
            $display("FAIL wr_count: writes=%0d required 2", we_addr_q.size() - wb);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (we_addr_q[wb + i] !== ea[i] || we_data_q[wb + i] !== ed[i]) begin
                    errors++;
                    $display("FAIL wr_entry%0d: addr=%h data=%h required %h/%h",
                             i, we_addr_q[wb + i], we_data_q[wb + i], ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_read_basic();
        int rb;
        logic [7:0] exp [3];
        bd_en = 1'b1; bd_addr = 7'h03; bd_data = 8'h33; tick();
        bd_addr = 7'h04; bd_data = 8'h44; tick();
        bd_en = 1'b0;
        ref_mem[3] = 8'h33;
        ref_mem[4] = 8'h44;
        exp[0] = ref_mem[3]; exp[1] = ref_mem[4]; exp[2] = ref_mem[5];
        rb = re_addr_q.size();
        start_frame();
        for (int k = 0; k < 3; k++) begin
            send_byte((k == 0) ? 8'h83 : 8'($urandom));
            tick();
            tick();
            checks++;
            if (spi_din !== exp[k]) begin
                errors++;
                $display("FAIL rd_byte%0d: spi_din=%h required %h", k, spi_din, exp[k]);
            end
        end
        end_frame();
        checks++;
        if (re_addr_q.size() != rb + 3) begin
            errors++;
            $display("FAIL rd_count: reads=%0d required 3", re_addr_q.size() - rb);
        end else if (re_addr_q[rb] !== 7'h03 || re_addr_q[rb + 1] !== 7'h04 || re_addr_q[rb + 2] !== 7'h05) begin
            errors++;
            $display("FAIL rd_addrs: %h %h %h required 03 04 05", re_addr_q[rb], re_addr_q[rb + 1], re_addr_q[rb + 2]);
        end
    endtask

`ifndef SPI_REG_CTRL_WPROT_EN
    task automatic test_wrap();
        int wb;
        logic [7:0] d [3];
        logic [6:0] ea [3];
        ea[0] = 7'h7E; ea[1] = 7'h7F; ea[2] = 7'h00;
        wb = we_addr_q.size();
        start_frame();
        send_byte(8'h7E);
        for (int i = 0; i < 3; i++) begin
            d[i] = 8'($urandom);
            send_byte(d[i]);
            ref_mem[ea[i]] = d[i];
        end
        end_frame();
        checks++;
        if (we_addr_q.size() != wb + 3) begin
            errors++;
            $display("FAIL wrap_count: writes=%0d required 3", we_addr_q.size() - wb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (we_addr_q[wb + i] !== ea[i] || we_data_q[wb + i] !== d[i]) begin
                    errors++;
                    $display("FAIL wrap_entry%0d: addr=%h data=%h required %h/%h",
                             i, we_addr_q[wb + i], we_data_q[wb + i], ea[i], d[i]);
                end
            end
        end
    endtask
`endif

    task automatic test_abort();
        int wb;
        int rb;
        wb = we_addr_q.size();
        rb = re_addr_q.size();
        start_frame();
        spi_select = 1'b0;
        tick();
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL abort_err: frame_err=%b required 1", frame_err);
        end
        tick();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_width: frame_err=%b required 0", frame_err);
        end
        // Bytes without a new start must be ignored once the controller is idle.
        spi_select = 1'b1;
        send_byte(8'h89);
        send_byte(8'h12);
        repeat (3) tick();
        spi_select = 1'b0;
        tick();
        checks++;
        if (we_addr_q.size() != wb || re_addr_q.size() != rb) begin
            errors++;
            $display("FAIL abort_strobes: writes=%0d reads=%0d required 0/0",
                     we_addr_q.size() - wb, re_addr_q.size() - rb);
        end
    endtask

    task automatic test_coincident();
        int wb;
        int rb;
        start_frame();
        send_byte(8'h83);
        tick();
        tick();
        checks++;
        if (spi_din !== ref_mem[3]) begin
            errors++;
            $display("FAIL coin_pre_read: spi_din=%h required %h", spi_din, ref_mem[3]);
        end
        repeat (2) tick();
        wb = we_addr_q.size();
        rb = re_addr_q.size();
        spi_start = 1'b1;
        spi_done  = 1'b1;
        spi_dout  = 8'hC1;
        tick();
        spi_start = 1'b0;
        spi_done  = 1'b0;
        checks++;
        if (spi_din !== 8'hA5) begin
            errors++;
            $display("FAIL coin_status: spi_din=%h required a5", spi_din);
        end
        repeat (3) tick();
        checks++;
        if (we_addr_q.size() != wb || re_addr_q.size() != rb) begin
            errors++;
            $display("FAIL coin_strobes: writes=%0d reads=%0d required 0/0",
                     we_addr_q.size() - wb, re_addr_q.size() - rb);
        end
        // The next byte is a fresh command byte.
        send_byte(8'h20);
        send_byte(8'h77);
        end_frame();
        ref_mem[32] = 8'h77;
        checks++;
        if (we_addr_q.size() != wb + 1) begin
            errors++;
            $display("FAIL coin_new_cmd: writes=%0d required 1", we_addr_q.size() - wb);
        end else if (we_addr_q[wb] !== 7'h20 || we_data_q[wb] !== 8'h77) begin
            errors++;
            $display("FAIL coin_new_cmd: addr=%h data=%h required 20/77", we_addr_q[wb], we_data_q[wb]);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 16; f++) begin
            int         a;
            int         n;
            int         wb;
            int         rb;
            logic       is_rd;
            logic [7:0] d [5];
            a     = $urandom_range(0, 112);
            n     = $urandom_range(1, 5);
            is_rd = 1'($urandom_range(0, 1));
            wb    = we_addr_q.size();
            rb    = re_addr_q.size();
            start_frame();
            if (is_rd) begin
                for (int k = 0; k < n; k++) begin
                    send_byte((k == 0) ? {1'b1, 7'(a)} : 8'($urandom));
                    tick();
                    tick();
                    checks++;
                    if (spi_din !== ref_mem[(a + k) % 128]) begin
                        errors++;
                        $display("FAIL rand_rd f%0d k%0d: spi_din=%h required %h",
                                 f, k, spi_din, ref_mem[(a + k) % 128]);
                    end
                end
            end else begin
                send_byte({1'b0, 7'(a)});
                for (int k = 0; k < n; k++) begin
                    d[k] = 8'($urandom);
                    send_byte(d[k]);
                    ref_mem[(a + k) % 128] = d[k];
                end
            end
            end_frame();
            checks++;
            if (is_rd) begin
                if (re_addr_q.size() != rb + n || we_addr_q.size() != wb) begin
                    errors++;
                    $display("FAIL rand_rd_count f%0d: reads=%0d writes=%0d required %0d/0",
                             f, re_addr_q.size() - rb, we_addr_q.size() - wb, n);
                end else begin
                    for (int k = 0; k < n; k++) begin
                        checks++;
                        if (re_addr_q[rb + k] !== 7'((a + k) % 128)) begin
                            errors++;
                            $display("FAIL rand_rd_addr f%0d k%0d: addr=%h required %h",
                                     f, k, re_addr_q[rb + k], 7'((a + k) % 128));
                        end
                    end
                end
            end else begin
                if (we_addr_q.size() != wb + n || re_addr_q.size() != rb) begin
                    errors++;
                    $display("FAIL rand_wr_count f%0d: writes=%0d reads=%0d required %0d/0",
                             f, we_addr_q.size() - wb, re_addr_q.size() - rb, n);
                end else begin
                    for (int k = 0; k < n; k++) begin
                        checks++;
                        if (we_addr_q[wb + k] !== 7'((a + k) % 128) || we_data_q[wb + k] !== d[k]) begin
                            errors++;
                            $display("FAIL rand_wr_entry f%0d k%0d: addr=%h data=%h required %h/%h",
                                     f, k, we_addr_q[wb + k], we_data_q[wb + k], 7'((a + k) % 128), d[k]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        int wb;
        int rb;
        wb = we_addr_q.size();
        rb = re_addr_q.size();
        start_frame();
        send_byte(8'h30);
        repeat (2) tick();
        spi_dout = 8'hEE;
        spi_done = 1'b1;
        rst      = 1'b1;
        tick();
        spi_done = 1'b0;
        rst      = 1'b0;
        checks++;
        if (reg_we !== 1'b0 || spi_din !== 8'h00 || reg_addr !== 7'h00) begin
            errors++;
            $display("FAIL rst_mid_state: we=%b din=%h addr=%h required 0/00/00", reg_we, spi_din, reg_addr);
        end
        send_byte(8'h99);
        send_byte(8'h98);
        repeat (3) tick();
        checks++;
        if (we_addr_q.size() != wb || re_addr_q.size() != rb || reg_addr !== 7'h00 || spi_din !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_ignore: writes=%0d reads=%0d addr=%h din=%h required 0/0/00/00",
                     we_addr_q.size() - wb, re_addr_q.size() - rb, reg_addr, spi_din);
        end
        end_frame();
    endtask

    initial begin
        rst        = 1'b1;
        spi_start  = 1'b0;
        spi_done   = 1'b0;
        spi_select = 1'b0;
        spi_dout   = 8'h00;
        bd_en      = 1'b0;
        bd_addr    = 7'h00;
        bd_data    = 8'h00;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;

        test_reset();
`ifdef SPI_REG_CTRL_WPROT_EN
        test_wprot();
`endif
        test_write_basic();
        test_read_basic();
`ifndef SPI_REG_CTRL_WPROT_EN
        test_wrap();
`endif
        test_abort();
        test_coincident();
        test_random();
        test_midframe_reset();

        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL we_re_overlap: cycles=%0d required 0", both_cnt);
        end
        checks++;
        if (ferr_cnt != 1) begin
            errors++;
            $display("FAIL frame_err_total: pulses=%0d required 1", ferr_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter STATUS, default 8'hA5: byte returned to the master while the command byte shifts.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port spi_start  input  1  one-cycle pulse from the byte engine when the master selects.
REQ-005 SHALL have port spi_done  input  1  one-cycle pulse when a byte has been shifted.
REQ-006 SHALL have port spi_select  input  1  clk-synchronized chip select level (active high).
REQ-007 SHALL have port spi_dout  input  8  byte received from the master; valid in the spi_done cycle.
REQ-008 SHALL have port spi_din  output  8  next byte to send to the master.
REQ-009 SHALL have port reg_addr  output  7  register address.
REQ-010 SHALL have port reg_wdata  output  8  write data.
REQ-011 SHALL have port reg_we  output  1  one-cycle write strobe.
REQ-012 SHALL have port reg_re  output  1  one-cycle read strobe; reg_rdata valid exactly 1 cycle later.
REQ-013 SHALL have port reg_rdata  input  8  read data.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse when a frame is aborted before its command byte completes.

Function
REQ-015 SHALL implement FSM states IDLE, CMD, WR, RD.
REQ-016 SHALL enter CMD on spi_start from any state, load spi_din=STATUS, and clear the lock-independent frame context.
REQ-017 SHALL, on spi_done in CMD, latch reg_addr=spi_dout[6:0] and go to RD if spi_dout[7]=1, otherwise WR.
REQ-018 SHALL, on CMD->RD, pulse reg_re in the next cycle and load spi_din from reg_rdata the cycle after, i.e. 2 cycles after spi_done.
REQ-019 SHALL, on each spi_done in RD, increment reg_addr, pulse reg_re 1 cycle later, and load spi_din 2 cycles after spi_done.
REQ-020 SHALL, on each spi_done in WR, drive reg_wdata=spi_dout and pulse reg_we in the next cycle at the current reg_addr, then increment reg_addr.
REQ-021 SHALL increment reg_addr modulo 128 (7'h7F -> 7'h00).
REQ-022 SHALL hold spi_din at 8'h00 in WR after the command byte.
REQ-023 SHALL return to IDLE in the cycle after spi_select is low; a pending reg_we or reg_re SHALL still issue once.
REQ-024 SHALL pulse frame_err for one cycle when spi_select falls while in CMD.
REQ-025 SHALL give spi_start priority when spi_start and spi_done coincide: the done is ignored.
REQ-026 SHALL ignore spi_done in IDLE.
REQ-027 SHALL never assert reg_we and reg_re in the same cycle.

Reset
REQ-028 SHALL, while rst is high, force state=IDLE, spi_din=8'h00, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, frame_err=0, and lock=1 when compiled in.
REQ-029 SHALL, when rst is asserted mid-frame, suppress pending strobes and ignore the remainder of that frame until the next spi_start.

Configuration
REQ-030 SHALL, with SPI_REG_CTRL_WPROT_EN defined, implement an internal lock bit at address 7'h7F.
REQ-031 SHALL, with SPI_REG_CTRL_WPROT_EN defined, clear the lock when 8'h5A is written to 7'h7F and set it for any other value written there.
REQ-032 SHALL, with SPI_REG_CTRL_WPROT_EN defined, suppress reg_we while the lock is set, and never assert reg_we for 7'h7F.
REQ-033 SHALL, with SPI_REG_CTRL_WPROT_EN defined, return {7'b0,lock} for reads of 7'h7F without asserting reg_re.
REQ-034 SHALL, without SPI_REG_CTRL_WPROT_EN, treat 7'h7F as an ordinary external register with no lock logic.

Verification
REQ-035 SHALL cover a write: start, bytes 8'h05,8'h11,8'h22 -> reg_we at addr 5 data 8'h11, then addr 6 data 8'h22; spi_din=8'hA5 during byte 0.
REQ-036 SHALL cover a read: start, bytes 8'h83,x,x, with regs[3]=8'h33 and regs[4]=8'h44 -> spi_din=8'h33 2 cycles after the first done, then 8'h44.
REQ-037 SHALL cover wrap-around: write command 8'h7E with 3 data bytes -> addresses 7E, 7F, 00 (WPROT_EN undefined).
REQ-038 SHALL cover abort: start, then select low before the first done -> frame_err=1 for 1 cycle, no strobes, state IDLE.
REQ-039 SHALL cover coincident events: spi_start and spi_done in the same cycle -> state CMD, spi_din=8'hA5, no strobe.
REQ-040 SHALL cover write protect (WPROT_EN defined): write 8'h10 to addr 2 while locked -> no reg_we; write 8'h5A to 7'h7F, then 8'h10 to addr 2 -> reg_we issued; read 7'h7F -> 8'h00.
